// File: rtl/alu_pkg.sv
// Shared types, constants and CRC helper for the ALU serial receive path.
// The CRC function is also meant for reuse by the bus-functional model and scoreboard.
package alu_pkg;

  typedef enum logic {
    PktData = 1'b0,
    PktCmd  = 1'b1
  } packet_type_t;

  typedef enum logic [2:0] {
    OpAnd = 3'b000,
    OpOr  = 3'b001,
    OpAdd = 3'b100,
    OpSub = 3'b101
  } operation_t;

  // Field order gives out_err bit positions: [2]=data, [1]=crc, [0]=op.
  typedef struct packed {
    logic err_data;
    logic err_crc;
    logic err_op;
  } rx_err_t;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  // CRC4, x^4+x+1, init 0, processed from d[67] down to d[0].
  function automatic logic [3:0] crc4_d68(input logic [67:0] d);
    logic [3:0] c;
    logic       fb;
    c = '0;
    for (int i = 67; i >= 0; i--) begin
      fb = c[3] ^ d[i];
      c  = {c[2:0], 1'b0} ^ ({4{fb}} & 4'b0011);
    end
    return c;
  endfunction

endpackage

// File: rtl/alu_packet_deser.sv
// Packet deserialiser: start bit, type, 8 data bits MSB first, stop bit.
// Emits a one-cycle pkt_valid or pkt_frame_err after the stop bit is sampled.
module alu_packet_deser
  import alu_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       sin_i,
  output logic       pkt_valid_o,
  output logic       pkt_frame_err_o,
  output logic       pkt_type_o,
  output logic [7:0] pkt_byte_o
);

  typedef enum logic [1:0] {StIdle, StShift, StStop} deser_state_t;

  deser_state_t state_q, state_d;
  logic [3:0]   bit_cnt_q, bit_cnt_d;
  logic [8:0]   shreg_q, shreg_d;
  logic         valid_q, valid_d;
  logic         ferr_q, ferr_d;

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shreg_d   = shreg_q;
    valid_d   = 1'b0;
    ferr_d    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (sin_i == START_BIT) begin
          state_d   = StShift;
          bit_cnt_d = '0;
        end
      end
      StShift: begin
        shreg_d   = {shreg_q[7:0], sin_i};
        bit_cnt_d = bit_cnt_q + 4'd1;
        if (bit_cnt_q == 4'd8) state_d = StStop;
      end
      StStop: begin
        if (sin_i == STOP_BIT) valid_d = 1'b1;
        else                   ferr_d  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      bit_cnt_q <= '0;
      shreg_q   <= '0;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shreg_q   <= shreg_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
    end
  end

  // shreg_q holds until the next packet's first data bit, so it is stable with valid_q.
  assign pkt_valid_o     = valid_q;
  assign pkt_frame_err_o = ferr_q;
  assign pkt_type_o      = shreg_q[8];
  assign pkt_byte_o      = shreg_q[7:0];

endmodule

// File: rtl/alu_serial_rx.sv
// Serial receive front-end: assembles 8 DATA packets plus a CMD packet into an ALU
// command, checks length/CRC/opcode and presents the result over valid/ready.
module alu_serial_rx
  import alu_pkg::*;
#(
  parameter int unsigned DATA_BYTES = 8,
  parameter int unsigned CNT_W      = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sin,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_A,
  output logic [31:0] out_B,
  output logic [2:0]  out_op,
  output logic [2:0]  out_err,
  output logic        overrun
);

  typedef enum logic [1:0] {StCollect, StCheck, StHold} frame_state_t;

  localparam logic [CNT_W-1:0] DataBytesW = CNT_W'(DATA_BYTES);

  logic       pkt_valid, pkt_frame_err, pkt_type;
  logic [7:0] pkt_byte;

  alu_packet_deser u_deser (
    .clk            (clk),
    .rst            (rst),
    .sin_i          (sin),
    .pkt_valid_o    (pkt_valid),
    .pkt_frame_err_o(pkt_frame_err),
    .pkt_type_o     (pkt_type),
    .pkt_byte_o     (pkt_byte)
  );

  frame_state_t     state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [63:0]      data_q, data_d;
  logic             bad_len_q, bad_len_d;
  logic [2:0]       op_q, op_d;
  logic [3:0]       crc_q, crc_d;
  logic             valid_q, valid_d;
  logic [31:0]      a_q, a_d, b_q, b_d;
  logic [2:0]       out_op_q, out_op_d;
  rx_err_t          err_q, err_d, chk_err;
  logic             overrun_q, overrun_d;
  logic             handshake, is_data, is_cmd, op_ok;
  logic             unused_cmd_msb;

  assign handshake      = valid_q && out_ready;
  assign is_data        = pkt_valid && (pkt_type == PktData);
  assign is_cmd         = pkt_valid && (pkt_type == PktCmd);
  assign unused_cmd_msb = pkt_byte[7];

  always_comb begin
    case (op_q)
      OpAnd, OpOr, OpAdd, OpSub: op_ok = 1'b1;
      default:                   op_ok = 1'b0;
    endcase
    chk_err = '0;
    if (cnt_q != DataBytesW || bad_len_q)         chk_err.err_data = 1'b1;
    else if (crc4_d68({data_q, 1'b1, op_q}) != crc_q) chk_err.err_crc  = 1'b1;
    else if (!op_ok)                              chk_err.err_op   = 1'b1;
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    data_d    = data_q;
    bad_len_d = bad_len_q;
    op_d      = op_q;
    crc_d     = crc_q;
    valid_d   = valid_q;
    a_d       = a_q;
    b_d       = b_q;
    out_op_d  = out_op_q;
    err_d     = err_q;
    overrun_d = overrun_q;
    unique case (state_q)
      StCollect, StHold: begin
        if (handshake) valid_d = 1'b0;
        if (pkt_frame_err) bad_len_d = 1'b1;
        if (is_data) begin
          data_d = {data_q[55:0], pkt_byte};
          if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
        end
        if (is_cmd) begin
          // A completed frame while the previous result is still pending is dropped.
          if (state_q == StHold && !handshake) begin
            overrun_d = 1'b1;
            cnt_d     = '0;
            bad_len_d = 1'b0;
            state_d   = StHold;
          end else begin
            op_d    = pkt_byte[6:4];
            crc_d   = pkt_byte[3:0];
            state_d = StCheck;
          end
        end else if (state_q == StHold && handshake) begin
          state_d = StCollect;
        end
      end
      StCheck: begin
        b_d       = data_q[63:32];
        a_d       = data_q[31:0];
        out_op_d  = op_q;
        err_d     = chk_err;
        valid_d   = 1'b1;
        cnt_d     = '0;
        bad_len_d = 1'b0;
        state_d   = StHold;
      end
      default: state_d = StCollect;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StCollect;
      cnt_q     <= '0;
      data_q    <= '0;
      bad_len_q <= 1'b0;
      op_q      <= '0;
      crc_q     <= '0;
      valid_q   <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      out_op_q  <= '0;
      err_q     <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      data_q    <= data_d;
      bad_len_q <= bad_len_d;
      op_q      <= op_d;
      crc_q     <= crc_d;
      valid_q   <= valid_d;
      a_q       <= a_d;
      b_q       <= b_d;
      out_op_q  <= out_op_d;
      err_q     <= err_d;
      overrun_q <= overrun_d;
    end
  end

  assign out_valid = valid_q;
  assign out_A     = a_q;
  assign out_B     = b_q;
  assign out_op    = out_op_q;
  assign out_err   = err_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_alu_serial_rx.sv
// Directed bench for alu_serial_rx: frames driven bit-serially, results checked
// with immediate assertions against hand-derived values.
module tb_alu_serial_rx;

  logic        clk = 1'b0;
  logic        rst;
  logic        sin;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_A;
  logic [31:0] out_B;
  logic [2:0]  out_op;
  logic [2:0]  out_err;
  logic        overrun;

  int n_tests = 0;
  int n_fail  = 0;

  alu_serial_rx dut (
    .clk      (clk),
    .rst      (rst),
    .sin      (sin),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_A    (out_A),
    .out_B    (out_B),
    .out_op   (out_op),
    .out_err  (out_err),
    .overrun  (overrun)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  // Remainder of {B,A,1,op} * x^4 modulo x^4+x+1, by long division.
  function automatic logic [3:0] ref_crc(input logic [31:0] b, input logic [31:0] a,
                                         input logic [2:0] op);
    logic [71:0] r;
    r = {b, a, 1'b1, op, 4'b0000};
    for (int i = 71; i >= 4; i--) begin
      if (r[i]) r[i-:5] = r[i-:5] ^ 5'b10011;
    end
    return r[3:0];
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    sin = b;
    tick();
  endtask

  task automatic send_pkt(input logic typ, input logic [7:0] data, input logic stop = 1'b1);
    send_bit(1'b0);
    send_bit(typ);
    for (int i = 7; i >= 0; i--) send_bit(data[i]);
    send_bit(stop);
    sin = 1'b1;
  endtask

  task automatic send_frame(input logic [31:0] b, input logic [31:0] a, input logic [2:0] op,
                            input logic [3:0] crc);
    logic [63:0] d;
    d = {b, a};
    for (int i = 7; i >= 0; i--) send_pkt(1'b0, d[i*8+:8]);
    send_pkt(1'b1, {1'b0, op, crc});
  endtask

  task automatic wait_valid(input string tag);
    int k;
    k = 0;
    while (out_valid !== 1'b1 && k < 40) begin
      tick();
      k++;
    end
    chk(tag, out_valid, 1'b1);
  endtask

  task automatic accept(input string tag);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk(tag, out_valid, 1'b0);
  endtask

  initial begin
    logic [3:0] c;
    rst       = 1'b1;
    sin       = 1'b1;
    out_ready = 1'b0;
    repeat (3) tick();
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_err", out_err, 3'b000);
    chk("rst_A", out_A, 32'h0);
    chk("rst_overrun", overrun, 1'b0);
    rst = 1'b0;
    repeat (2) tick();

    // 1: good ADD frame, exact latency
    c = ref_crc(32'h2, 32'h1, 3'b100);
    send_frame(32'h0000_0002, 32'h0000_0001, 3'b100, c);
    chk("t1_lat0", out_valid, 1'b0);
    tick();
    chk("t1_lat1", out_valid, 1'b0);
    tick();
    chk("t1_lat2", out_valid, 1'b1);
    chk("t1_A", out_A, 32'h1);
    chk("t1_B", out_B, 32'h2);
    chk("t1_op", out_op, 3'b100);
    chk("t1_err", out_err, 3'b000);
    accept("t1_ack");

    // 2: CRC inverted
    send_frame(32'h0000_0002, 32'h0000_0001, 3'b100, ~c);
    wait_valid("t2_valid");
    chk("t2_err", out_err, 3'b010);
    accept("t2_ack");

    // 3: short frame then a good one
    for (int i = 0; i < 5; i++) send_pkt(1'b0, 8'h11 * (i + 1));
    send_pkt(1'b1, {1'b0, 3'b000, 4'h0});
    wait_valid("t3a_valid");
    chk("t3a_err", out_err, 3'b100);
    accept("t3a_ack");
    send_frame(32'hDEAD_BEEF, 32'h1234_5678, 3'b101, ref_crc(32'hDEAD_BEEF, 32'h1234_5678, 3'b101));
    wait_valid("t3b_valid");
    chk("t3b_err", out_err, 3'b000);
    chk("t3b_A", out_A, 32'h1234_5678);
    chk("t3b_B", out_B, 32'hDEAD_BEEF);
    chk("t3b_op", out_op, 3'b101);
    accept("t3b_ack");

    // 4: invalid opcode with matching CRC
    send_frame(32'hA5A5_0000, 32'h0000_5A5A, 3'b110, ref_crc(32'hA5A5_0000, 32'h0000_5A5A, 3'b110));
    wait_valid("t4_valid");
    chk("t4_err", out_err, 3'b001);
    chk("t4_op", out_op, 3'b110);
    accept("t4_ack");

    // 5: two frames while out_ready stays low
    send_frame(32'h0000_00F0, 32'h0000_000F, 3'b001, ref_crc(32'hF0, 32'h0F, 3'b001));
    send_frame(32'h1111_1111, 32'h2222_2222, 3'b000, ref_crc(32'h1111_1111, 32'h2222_2222, 3'b000));
    repeat (4) tick();
    chk("t5_valid", out_valid, 1'b1);
    chk("t5_overrun", overrun, 1'b1);
    chk("t5_A", out_A, 32'h0F);
    chk("t5_B", out_B, 32'hF0);
    chk("t5_op", out_op, 3'b001);
    chk("t5_err", out_err, 3'b000);
    accept("t5_ack");
    repeat (30) tick();
    chk("t5_single", out_valid, 1'b0);
    chk("t5_sticky", overrun, 1'b1);

    // 6: reset mid-frame and mid-packet, then a fresh frame
    for (int i = 0; i < 3; i++) send_pkt(1'b0, 8'hC3);
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b1);
    rst = 1'b1;
    sin = 1'b1;
    tick();
    rst = 1'b0;
    chk("t6_rst_overrun", overrun, 1'b0);
    chk("t6_rst_valid", out_valid, 1'b0);
    tick();
    send_frame(32'h8000_0000, 32'hFFFF_FFFF, 3'b000, ref_crc(32'h8000_0000, 32'hFFFF_FFFF, 3'b000));
    wait_valid("t6_valid");
    chk("t6_err", out_err, 3'b000);
    chk("t6_A", out_A, 32'hFFFF_FFFF);
    chk("t6_B", out_B, 32'h8000_0000);
    chk("t6_op", out_op, 3'b000);
    accept("t6_ack");
    repeat (20) tick();
    chk("t6_once", out_valid, 1'b0);
    for (int i = 0; i < 8; i++) send_pkt(1'b0, 8'h01, (i == 3) ? 1'b0 : 1'b1);
    send_pkt(1'b1, {1'b0, 3'b000, 4'h0});
    wait_valid("t6b_valid");
    chk("t6b_err", out_err, 3'b100);
    accept("t6b_ack");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
